// File: rtl/aes_pkg.sv
// AES shared types, S-box ROM, GF(2^8) helpers and key-schedule constants.
package aes_pkg;
    typedef logic [7:0]              byte_t;
    typedef logic [31:0]             word_t;
    typedef logic [3:0][3:0][7:0]    block_t;  // [3-col][3-row]: S0,0 lands in [127:120]
    typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

    function automatic int nk_of(input int k);
        return k / 32;
    endfunction

    function automatic int nr_of(input int k);
        return k / 32 + 6;
    endfunction

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

    function automatic byte_t sbox(input byte_t x);
        return SBOX[2047 - 8*int'(x) -: 8];
    endfunction

    function automatic word_t sub_word(input word_t w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic byte_t rcon(input logic [3:0] i);
        case (i)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic byte_t xtime(input byte_t x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // Row 0 of the column sits in [31:24].
    function automatic word_t mix_column(input word_t w);
        byte_t a0, a1, a2, a3;
        {a0, a1, a2, a3} = w;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction
endpackage

// File: rtl/aes_key_window.sv
// Sliding Nk-word key-schedule window; emits 4 fresh round-key words per load/advance.
module aes_key_window
    import aes_pkg::*;
#(
    parameter int NK = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            load,
    input  logic            advance,
    input  logic [32*NK-1:0] key,
    output logic [127:0]    round_key
);
    logic [NK-1:0][31:0] win_q, src, nxt;
    logic [2:0]          m_q, m_src;     // (index of next word to generate) mod Nk
    logic [3:0]          rci_q, rci_src; // Rcon index for the next i mod Nk == 0 word
    logic [3:0][31:0]    prv, gen;
    logic                hit, rot;
    int                  jsub;
    word_t               sub_in, sub_out, temp_sub, prev, prev2;

    // Loading generates w[Nk..Nk+3] straight away so the window is already at round 1.
    always_comb begin
        src     = load ? key : win_q;
        m_src   = load ? 3'd0 : m_q;
        rci_src = load ? 4'd1 : rci_q;
    end

    // At most one word in any 4 consecutive needs SubWord, so a single 4-S-box path
    // is shared; its input is the plain-XOR chain up to that word.
    always_comb begin
        hit = 1'b0; rot = 1'b0; jsub = 0; prv = '0; sub_in = '0;
        prev = src[0];
        for (int j = 0; j < 4; j++) begin
            if (!hit && (((int'(m_src) + j) % NK) == 0 ||
                         (NK == 8 && ((int'(m_src) + j) % NK) == 4))) begin
                hit  = 1'b1;
                rot  = (((int'(m_src) + j) % NK) == 0);
                jsub = j;
            end
            prv[j] = prev;
            prev   = src[NK-1-j] ^ prev;
        end
        for (int j = 0; j < 4; j++)
            if (j == jsub) sub_in = prv[j];
    end

    assign sub_out  = sub_word(sub_in);
    assign temp_sub = rot ? ({sub_out[23:0], sub_out[31:24]} ^ {rcon(rci_src), 24'h0}) : sub_out;

    always_comb begin
        gen   = '0;
        prev2 = src[0];
        for (int j = 0; j < 4; j++) begin
            gen[j] = src[NK-1-j] ^ ((hit && j == jsub) ? temp_sub : prev2);
            prev2  = gen[j];
        end
    end

    if (NK > 4) begin : g_keep
        assign nxt = {src[NK-5:0], gen[0], gen[1], gen[2], gen[3]};
    end else begin : g_full
        assign nxt = {gen[0], gen[1], gen[2], gen[3]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            win_q <= '0;
            m_q   <= '0;
            rci_q <= '0;
        end else if (load || advance) begin
            win_q <= nxt;
            m_q   <= 3'((int'(m_src) + 4) % NK);
            rci_q <= rci_src + {3'b0, hit & rot};
        end
    end

    assign round_key = win_q[NK-1:NK-4];
endmodule

// File: rtl/aes_enc_core.sv
// Iterative AES-128/192/256 encryptor, one round per clock, key expanded on the fly.
// Define AES_ENC_LAST_KEY_EN to expose the final round key on last_key.
module aes_enc_core
    import aes_pkg::*;
#(
    parameter int K = 128
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [K-1:0]   key,
    input  logic [127:0]   plaintext,
    output logic           busy,
    output logic           done,
    output logic [127:0]   cyphertext
`ifdef AES_ENC_LAST_KEY_EN
    ,
    output logic [127:0]   last_key
`endif
);
    localparam int NK = nk_of(K);
    localparam int NR = nr_of(K);

    state_t       state_q, state_d;
    logic [3:0]   round_q;
    block_t       st_q, sr, mc, rnd_out;
    logic [127:0] rk;
    logic         load, adv, last_rnd;

    assign last_rnd = (round_q == 4'(NR));

    aes_key_window #(.NK(NK)) u_kw (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .advance   (adv),
        .key       (key),
        .round_key (rk)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        adv     = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: if (start) begin
                load    = 1'b1;
                state_d = ROUND;
            end
            ROUND: begin
                busy = 1'b1;
                if (last_rnd) state_d = DONE;
                else          adv     = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                if (start) begin
                    load    = 1'b1;
                    state_d = ROUND;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sr = '0;
        mc = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[3-c][3-r] = sbox(st_q[3-((c+r)%4)][3-r]);
        for (int c = 0; c < 4; c++)
            mc[c] = last_rnd ? sr[c] : mix_column(sr[c]);
        rnd_out = mc ^ rk;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st_q       <= '0;
            round_q    <= '0;
            cyphertext <= '0;
        end else if (load) begin
            st_q    <= plaintext ^ key[K-1 -: 128];
            round_q <= 4'd1;
        end else if (state_q == ROUND) begin
            st_q    <= rnd_out;
            round_q <= round_q + 4'd1;
            if (last_rnd) cyphertext <= rnd_out;
        end
    end

`ifdef AES_ENC_LAST_KEY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                            last_key <= '0;
        else if (state_q == ROUND && last_rnd) last_key <= rk;
    end
`endif
endmodule
